// File: rtl/alu_bus_sequencer_if.sv
// rtl/alu_bus_sequencer_if.sv - decoder handshake and shared register-bus signals of alu_bus_sequencer
interface alu_bus_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                  start;
    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] rs_addr;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] bus_in;
    logic [DATA_WIDTH-1:0] bus_out;
    logic                  bus_out_en;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic                  reg_out_en;
    logic                  reg_in_en;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  flag_zero;
    logic                  flag_carry;

    modport master (
        input  start, opcode, rd_addr, rs_addr, imm, bus_in,
        output bus_out, bus_out_en, reg_addr, reg_out_en, reg_in_en,
               busy, done, err, flag_zero, flag_carry
    );

    modport slave (
        output start, opcode, rd_addr, rs_addr, imm, bus_in,
        input  bus_out, bus_out_en, reg_addr, reg_out_en, reg_in_en,
               busy, done, err, flag_zero, flag_carry
    );
endinterface

// File: rtl/alu_bus_sequencer.sv
// rtl/alu_bus_sequencer.sv - register-bus ALU instruction sequencer; optional ALU_SAT_EN saturating add/sub
module alu_bus_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input logic                clock,
    input logic                reset,
    alu_bus_sequencer_if.master sif
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WB, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d, rs_q, rs_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d, r_q, r_d;
    logic                  zero_q, zero_d, carry_q, carry_d;
    logic [W-1:0]          bus_out_q, bus_out_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic                  bus_out_en_q, bus_out_en_d;
    logic                  reg_out_en_q, reg_out_en_d;
    logic                  reg_in_en_q, reg_in_en_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [W:0]            sum_w;
    logic [W-1:0]          diff_w;
    logic [W-1:0]          alu_res;
    logic                  alu_carry;

    // ALU datapath on the latched operands; only consumed in EXEC
    always_comb begin
        sum_w     = {1'b0, a_q} + {1'b0, b_q};
        diff_w    = a_q - b_q;
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            4'd0, 4'd8: begin
                alu_carry = sum_w[W];
`ifdef ALU_SAT_EN
                alu_res = sum_w[W] ? {W{1'b1}} : sum_w[W-1:0];
`else
                alu_res = sum_w[W-1:0];
`endif
            end
            4'd1, 4'd9: begin
                alu_carry = (a_q < b_q);
`ifdef ALU_SAT_EN
                alu_res = (a_q < b_q) ? '0 : diff_w;
`else
                alu_res = diff_w;
`endif
            end
            4'd2:        alu_res = a_q & b_q;
            4'd3:        alu_res = a_q | b_q;
            4'd4:        alu_res = a_q ^ b_q;
            4'd5:        alu_res = a_q << b_q;   // amounts >= W shift everything out
            4'd6:        alu_res = a_q >> b_q;
            4'd7, 4'd10: alu_res = b_q;
            default:     alu_res = '0;
        endcase
    end

    // Next-state, operand latching and output decode (outputs are registered from the next state)
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sif.start) begin
                    op_d = sif.opcode;
                    rd_d = sif.rd_addr;
                    rs_d = sif.rs_addr;
                    if (sif.opcode >= 4'd8 && sif.opcode <= 4'd10) b_d = sif.imm;
                    case (sif.opcode)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                        4'd8, 4'd9: state_d = S_RD_A;
                        4'd7:       state_d = S_RD_B;
                        4'd10:      state_d = S_EXEC;
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_RD_A: begin
                a_d     = sif.bus_in;
                state_d = (op_q <= 4'd6) ? S_RD_B : S_EXEC;
            end
            S_RD_B: begin
                b_d     = sif.bus_in;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                r_d     = alu_res;
                zero_d  = (alu_res == '0);
                carry_d = alu_carry;
                state_d = S_WB;
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        reg_out_en_d = (state_d == S_RD_A) || (state_d == S_RD_B);
        bus_out_en_d = (state_d == S_WB);
        reg_in_en_d  = (state_d == S_WB);
        bus_out_d    = (state_d == S_WB) ? r_d : '0;
        if (state_d == S_RD_B)                            reg_addr_d = rs_d;
        else if (state_d == S_RD_A || state_d == S_WB)    reg_addr_d = rd_d;
        else                                              reg_addr_d = '0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, latches and registered outputs; async reset aborts and drops every enable
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            rd_q         <= '0;
            rs_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            r_q          <= '0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            bus_out_q    <= '0;
            reg_addr_q   <= '0;
            bus_out_en_q <= 1'b0;
            reg_out_en_q <= 1'b0;
            reg_in_en_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            rs_q         <= rs_d;
            a_q          <= a_d;
            b_q          <= b_d;
            r_q          <= r_d;
            zero_q       <= zero_d;
            carry_q      <= carry_d;
            bus_out_q    <= bus_out_d;
            reg_addr_q   <= reg_addr_d;
            bus_out_en_q <= bus_out_en_d;
            reg_out_en_q <= reg_out_en_d;
            reg_in_en_q  <= reg_in_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign sif.bus_out    = bus_out_q;
    assign sif.bus_out_en = bus_out_en_q;
    assign sif.reg_addr   = reg_addr_q;
    assign sif.reg_out_en = reg_out_en_q;
    assign sif.reg_in_en  = reg_in_en_q;
    assign sif.busy       = busy_q;
    assign sif.done       = done_q;
    assign sif.err        = err_q;
    assign sif.flag_zero  = zero_q;
    assign sif.flag_carry = carry_q;
endmodule
